// File: rtl/mem_requester.sv
// Single-outstanding memory requester: accepts one request, drives the RAM bus, waits for
// ram_state, then pulses one response. Optional WAIT timeout enabled by MEM_REQ_TIMEOUT_EN.
module mem_requester #(
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data,
    output logic        ram_wr,
    input  logic        ram_state,
    input  logic [31:0] ram_q,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a posedge where req_valid && req_ready; req_ready is
    // high only in IDLE. resp_valid is a one-cycle pulse with no back-pressure.
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam int CNT_MAX   = (WAIT_CYCLES > TIMEOUT) ? WAIT_CYCLES : TIMEOUT;
    localparam int CNT_W     = $clog2(CNT_MAX + 2);
    localparam int WAIT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    state_t             state_q, state_d;
    logic               wr_q;
    logic [31:0]        ram_addr_q;
    logic [31:0]        ram_data_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;

    logic accept;
    logic in_range;
    logic wait_done;
    logic timed_out;

    assign accept    = req_valid && (state_q == S_IDLE);
    assign in_range  = req_addr < 32'(DEPTH);
    assign wait_done = ram_state && (cnt_q >= CNT_W'(WAIT_LAST));

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    assign timed_out = !ram_state && (cnt_q >= CNT_W'(TO_LAST));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = in_range ? S_ISSUE : S_RESP;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (wait_done || timed_out) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_err   = (state_q == S_RESP) && err_q;
        ram_wr     = wr_q && ((state_q == S_ISSUE) || (state_q == S_WAIT));
        resp_rdata = rdata_q;
        ram_addr   = ram_addr_q;
        ram_data   = ram_data_q;
        dbg_state  = state_q;
    end

    // The RAM bus registers only move on an in-range accept, so they keep the last issued values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= 1'b0;
            ram_addr_q <= 32'h0;
            ram_data_q <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        wr_q    <= req_wr;
                        rdata_q <= 32'h0;
                        err_q   <= !in_range;
                        if (in_range) begin
                            ram_addr_q <= req_addr;
                            ram_data_q <= req_wdata;
                        end
                    end
                end
                S_ISSUE: cnt_q <= '0;
                S_WAIT: begin
                    if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
                    if (wait_done) begin
                        rdata_q <= wr_q ? 32'h0 : ram_q;
                        err_q   <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= 32'h0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
